cache_coherence_agent: RTL and testbench



---
 rtl/cache_coherence_agent.sv | 264 ++++++++++++++++++++++++++
 tb/tb_cache_coherence_agent.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_coherence_agent.sv
// Private direct-mapped cache controller and MESI requester/owner agent for one CPU.
// Handshake: cpu_req_en is a one-cycle pulse taken only while cpu_busy=0; each taken request yields one cpu_ready pulse.
module cache_coherence_agent #(
   parameter int CPU_ID     = 0,
   parameter int NUM_LINES  = 4,
   parameter int WIDTH      = 32,
   parameter int BLOCK_SIZE = 64,
   parameter int CPU_WIDTH  = 2
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic                  cpu_req_en,
   input  logic                  cpu_we,
   input  logic [WIDTH-1:0]      cpu_address,
   input  logic [BLOCK_SIZE-1:0] cpu_wdata,
   output logic                  cpu_busy,
   output logic                  cpu_ready,
   output logic [BLOCK_SIZE-1:0] cpu_rdata,
   output logic                  transaction_en_o,
   output logic [3:0]            transaction_type_o,
   output logic [WIDTH-1:0]      transaction_address_o,
   output logic [BLOCK_SIZE-1:0] transaction_data_o,
   output logic [CPU_WIDTH-1:0]  unicast_address,
   input  logic                  transaction_en_i,
   input  logic [3:0]            transaction_type_i,
   input  logic [WIDTH-1:0]      transaction_address_i,
   input  logic [BLOCK_SIZE-1:0] transaction_data_i,
   input  logic [CPU_WIDTH-1:0]  requesters_i,
   input  logic                  exclusive_i,
   input  logic                  put_ack_i,
   input  logic                  Inv_en_i,
   input  logic [CPU_WIDTH:0]    Inv_unicast_address_i,
   input  logic [WIDTH-1:0]      Inv_address_i,
   output logic [2:0]            fsm_state
);
   localparam int OFF_BITS = $clog2(BLOCK_SIZE / 8);
   localparam int IDX_BITS = $clog2(NUM_LINES);
   localparam int TAG_BITS = WIDTH - IDX_BITS - OFF_BITS;

   localparam logic [3:0] FWD_GET_S          = 4'd1;
   localparam logic [3:0] FWD_GET_M          = 4'd2;
   localparam logic [3:0] FWD_PUT_S          = 4'd3;
   localparam logic [3:0] FWD_PUT_E          = 4'd4;
   localparam logic [3:0] FWD_PUT_M          = 4'd5;
   localparam logic [3:0] FORWARD_DATA       = 4'd6;
   localparam logic [3:0] FORWARD_DATA_PUT_E = 4'd7;
   localparam logic [3:0] FORWARD_DATA_PUT_M = 4'd8;

   localparam logic [2:0] LS_I = 3'b000;
   localparam logic [2:0] LS_E = 3'b100;
   localparam logic [2:0] LS_S = 3'b101;
   localparam logic [2:0] LS_M = 3'b110;

   typedef enum logic [2:0] {
      IDLE, EVICT, WAIT_PUT_ACK, GET, WAIT_DATA, FWD_DATA, FWD_WB, DONE
   } state_t;

   state_t state, next_state, ret_state;

   logic [2:0]            line_state [NUM_LINES];
   logic [TAG_BITS-1:0]   line_tag   [NUM_LINES];
   logic [BLOCK_SIZE-1:0] line_data  [NUM_LINES];

   logic                  req_active, req_we;
   logic [WIDTH-1:0]      req_addr;
   logic [BLOCK_SIZE-1:0] req_wdata;
   logic [IDX_BITS-1:0]   fwd_idx;
   logic [WIDTH-1:0]      fwd_addr;
   logic [CPU_WIDTH-1:0]  fwd_req;
   logic                  fwd_is_s, fwd_was_m;

   logic                  accept, have_req, cur_we;
   logic [WIDTH-1:0]      cur_addr;
   logic [BLOCK_SIZE-1:0] cur_wdata;
   logic [IDX_BITS-1:0]   c_idx, r_idx, f_idx, inv_idx;
   logic [2:0]            c_state;
   logic                  c_hit, inv_kill, fwd_hit, data_hit;

   logic                  tx_en_n, ready_n;
   logic [3:0]            tx_type_n;
   logic [WIDTH-1:0]      tx_addr_n;
   logic [BLOCK_SIZE-1:0] tx_data_n, rdata_n;
   logic [CPU_WIDTH-1:0]  ucast_n;

   logic unused_inv_bits;
   assign unused_inv_bits = ^{Inv_unicast_address_i, Inv_address_i[OFF_BITS-1:0]};

   // A request taken while a forward is being served stays pending in req_* until IDLE returns.
   assign accept    = (state == IDLE) && cpu_req_en && !cpu_busy;
   assign have_req  = accept || req_active;
   assign cur_we    = accept ? cpu_we      : req_we;
   assign cur_addr  = accept ? cpu_address : req_addr;
   assign cur_wdata = accept ? cpu_wdata   : req_wdata;

   assign c_idx   = cur_addr[OFF_BITS +: IDX_BITS];
   assign r_idx   = req_addr[OFF_BITS +: IDX_BITS];
   assign f_idx   = transaction_address_i[OFF_BITS +: IDX_BITS];
   assign inv_idx = Inv_address_i[OFF_BITS +: IDX_BITS];

   assign inv_kill = Inv_en_i && Inv_unicast_address_i[CPU_ID] && (line_state[inv_idx] == LS_S) &&
                     (line_tag[inv_idx] == Inv_address_i[WIDTH-1 -: TAG_BITS]);
   // Invalidation wins over a same-cycle CPU lookup of the same line.
   assign c_state = (inv_kill && (inv_idx == c_idx)) ? LS_I : line_state[c_idx];
   assign c_hit   = (c_state != LS_I) && (line_tag[c_idx] == cur_addr[WIDTH-1 -: TAG_BITS]);

   assign fwd_hit = transaction_en_i &&
                    ((state == IDLE) || (state == WAIT_PUT_ACK) || (state == WAIT_DATA)) &&
                    ((transaction_type_i == FWD_GET_S) || (transaction_type_i == FWD_GET_M)) &&
                    ((line_state[f_idx] == LS_E) || (line_state[f_idx] == LS_M)) &&
                    (line_tag[f_idx] == transaction_address_i[WIDTH-1 -: TAG_BITS]);
   assign data_hit = (state == WAIT_DATA) && transaction_en_i &&
                     (transaction_type_i == FORWARD_DATA) && (transaction_address_i == req_addr);

   assign fsm_state = state;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) state <= IDLE;
      else         state <= next_state;
   end

   always_comb begin
      next_state = state;
      tx_en_n    = 1'b0;
      tx_type_n  = '0;
      tx_addr_n  = '0;
      tx_data_n  = '0;
      ucast_n    = '0;
      ready_n    = 1'b0;
      rdata_n    = '0;
      case (state)
         IDLE: begin
            if (fwd_hit) next_state = FWD_DATA;
            else if (have_req) begin
               if (c_hit && (!cur_we || (c_state != LS_S))) next_state = DONE;
               else if (c_hit || (c_state == LS_I))        next_state = GET;
               else                                         next_state = EVICT;
            end
         end
         EVICT: begin
            next_state = WAIT_PUT_ACK;
            tx_en_n    = 1'b1;
            tx_addr_n  = {line_tag[r_idx], r_idx, {OFF_BITS{1'b0}}};
            case (line_state[r_idx])
               LS_M: begin
                  tx_type_n = FWD_PUT_M;
                  tx_data_n = line_data[r_idx];
               end
               LS_E:    tx_type_n = FWD_PUT_E;
               default: tx_type_n = FWD_PUT_S;
            endcase
         end
         WAIT_PUT_ACK: begin
            if (fwd_hit)        next_state = FWD_DATA;
            else if (put_ack_i) next_state = GET;
         end
         GET: begin
            next_state = WAIT_DATA;
            tx_en_n    = 1'b1;
            tx_type_n  = req_we ? FWD_GET_M : FWD_GET_S;
            tx_addr_n  = req_addr;
         end
         WAIT_DATA: begin
            if (fwd_hit)       next_state = FWD_DATA;
            else if (data_hit) next_state = DONE;
         end
         FWD_DATA: begin
            next_state = fwd_is_s ? FWD_WB : ret_state;
            tx_en_n    = 1'b1;
            tx_type_n  = FORWARD_DATA;
            tx_addr_n  = fwd_addr;
            tx_data_n  = line_data[fwd_idx];
            ucast_n    = fwd_req;
         end
         FWD_WB: begin
            next_state = ret_state;
            tx_en_n    = 1'b1;
            tx_addr_n  = fwd_addr;
            if (fwd_was_m) begin
               tx_type_n = FORWARD_DATA_PUT_M;
               tx_data_n = line_data[fwd_idx];
            end else begin
               tx_type_n = FORWARD_DATA_PUT_E;
            end
         end
         DONE: begin
            next_state = IDLE;
            ready_n    = 1'b1;
            rdata_n    = req_we ? '0 : line_data[r_idx];
         end
         default: next_state = IDLE;
      endcase
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         cpu_busy              <= 1'b0;
         cpu_ready             <= 1'b0;
         cpu_rdata             <= '0;
         transaction_en_o      <= 1'b0;
         transaction_type_o    <= '0;
         transaction_address_o <= '0;
         transaction_data_o    <= '0;
         unicast_address       <= '0;
         req_active            <= 1'b0;
         req_we                <= 1'b0;
         req_addr              <= '0;
         req_wdata             <= '0;
         fwd_idx               <= '0;
         fwd_addr              <= '0;
         fwd_req               <= '0;
         fwd_is_s              <= 1'b0;
         fwd_was_m             <= 1'b0;
         ret_state             <= IDLE;
         for (int i = 0; i < NUM_LINES; i++) begin
            line_state[i] <= LS_I;
            line_tag[i]   <= '0;
            line_data[i]  <= '0;
         end
      end else begin
         cpu_ready             <= ready_n;
         cpu_rdata             <= rdata_n;
         transaction_en_o      <= tx_en_n;
         transaction_type_o    <= tx_type_n;
         transaction_address_o <= tx_addr_n;
         transaction_data_o    <= tx_data_n;
         unicast_address       <= ucast_n;
         cpu_busy              <= accept || req_active;
         req_active            <= (accept || req_active) && (state != DONE);
         if (accept) begin
            req_we    <= cpu_we;
            req_addr  <= cpu_address;
            req_wdata <= cpu_wdata;
         end
         if (inv_kill) line_state[inv_idx] <= LS_I;
         if (fwd_hit) begin
            fwd_idx   <= f_idx;
            fwd_addr  <= transaction_address_i;
            fwd_req   <= requesters_i;
            fwd_is_s  <= (transaction_type_i == FWD_GET_S);
            fwd_was_m <= (line_state[f_idx] == LS_M);
            ret_state <= state;
         end
         case (state)
            IDLE: if (!fwd_hit && have_req && c_hit && cur_we && (c_state != LS_S)) begin
               line_data[c_idx]  <= cur_wdata;
               line_state[c_idx] <= LS_M;
            end
            WAIT_PUT_ACK: if (!fwd_hit && put_ack_i) line_state[r_idx] <= LS_I;
            WAIT_DATA: if (data_hit) begin
               line_tag[r_idx] <= req_addr[WIDTH-1 -: TAG_BITS];
               if (req_we) begin
                  line_data[r_idx]  <= req_wdata;
                  line_state[r_idx] <= LS_M;
               end else begin
                  line_data[r_idx]  <= transaction_data_i;
                  line_state[r_idx] <= exclusive_i ? LS_E : LS_S;
               end
            end
            FWD_DATA: line_state[fwd_idx] <= fwd_is_s ? LS_S : LS_I;
            default: ;
         endcase
      end
   end
endmodule

// File: tb/tb_cache_coherence_agent.sv
// Directed bench for cache_coherence_agent: miss/hit, upgrade, forward service, eviction, invalidation, reset.
module tb_cache_coherence_agent;
   localparam int WIDTH = 32;
   localparam int BS    = 64;
   localparam int CW    = 2;

   localparam logic [3:0] FWD_GET_S          = 4'd1;
   localparam logic [3:0] FWD_GET_M          = 4'd2;
   localparam logic [3:0] FWD_PUT_M          = 4'd5;
   localparam logic [3:0] FORWARD_DATA       = 4'd6;
   localparam logic [3:0] FORWARD_DATA_PUT_M = 4'd8;

   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic             cpu_req_en = 1'b0, cpu_we = 1'b0;
   logic [WIDTH-1:0] cpu_address = '0;
   logic [BS-1:0]    cpu_wdata = '0;
   logic             cpu_busy, cpu_ready;
   logic [BS-1:0]    cpu_rdata;
   logic             transaction_en_o;
   logic [3:0]       transaction_type_o;
   logic [WIDTH-1:0] transaction_address_o;
   logic [BS-1:0]    transaction_data_o;
   logic [CW-1:0]    unicast_address;
   logic             transaction_en_i = 1'b0;
   logic [3:0]       transaction_type_i = '0;
   logic [WIDTH-1:0] transaction_address_i = '0;
   logic [BS-1:0]    transaction_data_i = '0;
   logic [CW-1:0]    requesters_i = '0;
   logic             exclusive_i = 1'b0, put_ack_i = 1'b0, Inv_en_i = 1'b0;
   logic [CW:0]      Inv_unicast_address_i = '0;
   logic [WIDTH-1:0] Inv_address_i = '0;
   logic [2:0]       fsm_state;

   int tests = 0;
   int fails = 0;
   int cyc, msgs, rdy;

   cache_coherence_agent #(.CPU_ID(0), .NUM_LINES(4), .WIDTH(WIDTH), .BLOCK_SIZE(BS), .CPU_WIDTH(CW)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst),
      .cpu_req_en(cpu_req_en), .cpu_we(cpu_we), .cpu_address(cpu_address), .cpu_wdata(cpu_wdata),
      .cpu_busy(cpu_busy), .cpu_ready(cpu_ready), .cpu_rdata(cpu_rdata),
      .transaction_en_o(transaction_en_o), .transaction_type_o(transaction_type_o),
      .transaction_address_o(transaction_address_o), .transaction_data_o(transaction_data_o),
      .unicast_address(unicast_address),
      .transaction_en_i(transaction_en_i), .transaction_type_i(transaction_type_i),
      .transaction_address_i(transaction_address_i), .transaction_data_i(transaction_data_i),
      .requesters_i(requesters_i), .exclusive_i(exclusive_i), .put_ack_i(put_ack_i),
      .Inv_en_i(Inv_en_i), .Inv_unicast_address_i(Inv_unicast_address_i), .Inv_address_i(Inv_address_i),
      .fsm_state(fsm_state)
   );

   always #5 sys_clk = ~sys_clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic cpu_req(input logic we, input logic [WIDTH-1:0] addr, input logic [BS-1:0] wdata);
      @(negedge sys_clk);
      cpu_req_en = 1'b1; cpu_we = we; cpu_address = addr; cpu_wdata = wdata;
      @(negedge sys_clk);
      cpu_req_en = 1'b0; cpu_we = 1'b0; cpu_wdata = '0;
   endtask

   task automatic inbound(input logic [3:0] typ, input logic [WIDTH-1:0] addr, input logic [BS-1:0] data,
                          input logic [CW-1:0] req, input logic excl);
      @(negedge sys_clk);
      transaction_en_i = 1'b1; transaction_type_i = typ; transaction_address_i = addr;
      transaction_data_i = data; requesters_i = req; exclusive_i = excl;
      @(negedge sys_clk);
      transaction_en_i = 1'b0; transaction_type_i = '0; transaction_address_i = '0;
      transaction_data_i = '0; requesters_i = '0; exclusive_i = 1'b0;
   endtask

   task automatic inv_pulse(input logic [CW:0] onehot, input logic [WIDTH-1:0] addr);
      @(negedge sys_clk);
      Inv_en_i = 1'b1; Inv_unicast_address_i = onehot; Inv_address_i = addr;
      @(negedge sys_clk);
      Inv_en_i = 1'b0; Inv_unicast_address_i = '0; Inv_address_i = '0;
   endtask

   task automatic ack_pulse();
      @(negedge sys_clk);
      put_ack_i = 1'b1;
      @(negedge sys_clk);
      put_ack_i = 1'b0;
   endtask

   task automatic wait_msg(input string tag, output int n);
      n = 0;
      while (!transaction_en_o && n < 20) begin
         @(negedge sys_clk);
         n++;
      end
      chk({tag, "_seen"}, transaction_en_o, 1'b1);
   endtask

   task automatic wait_ready(input string tag, output int n, output int m);
      n = 0; m = 0;
      while (!cpu_ready && n < 20) begin
         @(negedge sys_clk);
         n++;
         if (transaction_en_o) m++;
      end
      chk({tag, "_ready"}, cpu_ready, 1'b1);
   endtask

   task automatic check_msg(input string tag, input logic [3:0] typ, input logic [WIDTH-1:0] addr,
                            input logic [BS-1:0] data, input logic [CW-1:0] uc);
      chk({tag, "_en"},   transaction_en_o, 1'b1);
      chk({tag, "_type"}, transaction_type_o, typ);
      chk({tag, "_addr"}, transaction_address_o, addr);
      chk({tag, "_data"}, transaction_data_o, data);
      chk({tag, "_uc"},   unicast_address, uc);
   endtask

   task automatic check_idle_outputs(input string tag);
      chk({tag, "_busy"},  cpu_busy, 1'b0);
      chk({tag, "_ready"}, cpu_ready, 1'b0);
      chk({tag, "_rdata"}, cpu_rdata, 64'h0);
      chk({tag, "_en"},    transaction_en_o, 1'b0);
      chk({tag, "_type"},  transaction_type_o, 4'h0);
      chk({tag, "_addr"},  transaction_address_o, 32'h0);
      chk({tag, "_data"},  transaction_data_o, 64'h0);
      chk({tag, "_uc"},    unicast_address, 2'h0);
      chk({tag, "_fsm"},   fsm_state, 3'd0);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge sys_clk);
      check_idle_outputs("rst");
      sys_rst = 1'b0;

      // Cold load miss, exclusive fill
      cpu_req(1'b0, 32'h40, '0);
      chk("ld_miss_busy", cpu_busy, 1'b1);
      wait_msg("ld_miss_get", cyc);
      chk("ld_miss_get_lat", cyc, 1);
      check_msg("ld_miss_get", FWD_GET_S, 32'h40, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h40, 64'h1234, 2'd0, 1'b1);
      wait_ready("ld_miss", cyc, msgs);
      chk("ld_miss_lat", cyc, 1);
      chk("ld_miss_rdata", cpu_rdata, 64'h1234);

      // Load hit on the E line
      cpu_req(1'b0, 32'h40, '0);
      wait_ready("ld_hit", cyc, msgs);
      chk("ld_hit_lat", cyc, 1);
      chk("ld_hit_msgs", msgs, 0);
      chk("ld_hit_rdata", cpu_rdata, 64'h1234);
      @(negedge sys_clk);
      chk("ld_hit_busy_drop", cpu_busy, 1'b0);

      // Silent store to the E line
      cpu_req(1'b1, 32'h40, 64'hBEEF);
      wait_ready("st_e", cyc, msgs);
      chk("st_e_lat", cyc, 1);
      chk("st_e_msgs", msgs, 0);
      chk("st_e_rdata", cpu_rdata, 64'h0);

      // Forwarded GetS on the M line from CPU 1
      inbound(FWD_GET_S, 32'h40, '0, 2'd1, 1'b0);
      wait_msg("fgs_data", cyc);
      chk("fgs_data_lat", cyc, 1);
      check_msg("fgs_data", FORWARD_DATA, 32'h40, 64'hBEEF, 2'd1);
      @(negedge sys_clk);
      check_msg("fgs_wb", FORWARD_DATA_PUT_M, 32'h40, 64'hBEEF, 2'd0);
      @(negedge sys_clk);
      chk("fgs_end", transaction_en_o, 1'b0);

      // Invalidation aimed at another CPU leaves the S line
      inv_pulse(3'b010, 32'h40);
      cpu_req(1'b0, 32'h40, '0);
      wait_ready("inv_other", cyc, msgs);
      chk("inv_other_msgs", msgs, 0);
      chk("inv_other_rdata", cpu_rdata, 64'hBEEF);

      // Invalidation aimed at this CPU makes the next load miss
      inv_pulse(3'b001, 32'h40);
      cpu_req(1'b0, 32'h40, '0);
      wait_msg("inv_self_get", cyc);
      chk("inv_self_get_lat", cyc, 1);
      check_msg("inv_self_get", FWD_GET_S, 32'h40, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h40, 64'hAAAA, 2'd0, 1'b0);
      wait_ready("inv_self", cyc, msgs);
      chk("inv_self_rdata", cpu_rdata, 64'hAAAA);

      // Store hit on S upgrades with GetM; line then holds the store data
      cpu_req(1'b1, 32'h40, 64'hCAFE);
      wait_msg("upg_get", cyc);
      chk("upg_get_lat", cyc, 1);
      check_msg("upg_get", FWD_GET_M, 32'h40, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h40, 64'h9999, 2'd0, 1'b0);
      wait_ready("upg", cyc, msgs);
      chk("upg_rdata", cpu_rdata, 64'h0);
      cpu_req(1'b0, 32'h40, '0);
      wait_ready("upg_chk", cyc, msgs);
      chk("upg_chk_msgs", msgs, 0);
      chk("upg_chk_rdata", cpu_rdata, 64'hCAFE);

      // Conflict miss evicts the M line and waits for the put ack
      cpu_req(1'b0, 32'h60, '0);
      wait_msg("evict_put", cyc);
      chk("evict_put_lat", cyc, 1);
      check_msg("evict_put", FWD_PUT_M, 32'h40, 64'hCAFE, 2'd0);
      msgs = 0; rdy = 0;
      repeat (5) begin
         @(negedge sys_clk);
         if (transaction_en_o) msgs++;
         if (cpu_ready) rdy++;
      end
      chk("evict_hold_msgs", msgs, 0);
      chk("evict_hold_ready", rdy, 0);
      chk("evict_hold_fsm", fsm_state, 3'd2);
      ack_pulse();
      wait_msg("evict_get", cyc);
      chk("evict_get_lat", cyc, 1);
      check_msg("evict_get", FWD_GET_S, 32'h60, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h60, 64'h5555, 2'd0, 1'b0);
      wait_ready("evict", cyc, msgs);
      chk("evict_rdata", cpu_rdata, 64'h5555);

      // Reset while waiting for data
      cpu_req(1'b0, 32'h48, '0);
      wait_msg("rstmid_get", cyc);
      check_msg("rstmid_get", FWD_GET_S, 32'h48, 64'h0, 2'd0);
      @(negedge sys_clk);
      sys_rst = 1'b1;
      #1;
      check_idle_outputs("rstmid");
      @(negedge sys_clk);
      sys_rst = 1'b0;
      inbound(FORWARD_DATA, 32'h48, 64'h7777, 2'd0, 1'b1);
      msgs = 0; rdy = 0;
      repeat (4) begin
         @(negedge sys_clk);
         if (transaction_en_o) msgs++;
         if (cpu_ready) rdy++;
      end
      chk("rstmid_stale_msgs", msgs, 0);
      chk("rstmid_stale_ready", rdy, 0);
      chk("rstmid_stale_busy", cpu_busy, 1'b0);

      // Line that was S before reset now misses without a Put
      cpu_req(1'b0, 32'h60, '0);
      wait_msg("post_rst_get", cyc);
      chk("post_rst_get_lat", cyc, 1);
      check_msg("post_rst_get", FWD_GET_S, 32'h60, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h60, 64'h6060, 2'd0, 1'b1);
      wait_ready("post_rst", cyc, msgs);
      chk("post_rst_rdata", cpu_rdata, 64'h6060);

      // Forwarded GetM on the E line from CPU 2: data only, line dropped
      inbound(FWD_GET_M, 32'h60, '0, 2'd2, 1'b0);
      wait_msg("fgm_data", cyc);
      chk("fgm_data_lat", cyc, 1);
      check_msg("fgm_data", FORWARD_DATA, 32'h60, 64'h6060, 2'd2);
      @(negedge sys_clk);
      chk("fgm_no_wb", transaction_en_o, 1'b0);
      chk("fgm_fsm", fsm_state, 3'd0);
      cpu_req(1'b0, 32'h60, '0);
      wait_msg("fgm_reload", cyc);
      check_msg("fgm_reload", FWD_GET_S, 32'h60, 64'h0, 2'd0);
      inbound(FORWARD_DATA, 32'h60, 64'h0ABC, 2'd0, 1'b0);
      wait_ready("fgm_reload", cyc, msgs);
      chk("fgm_reload_rdata", cpu_rdata, 64'h0ABC);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
